// File: rtl/fp_divider.sv
// Iterative FP32 divider (a / b): restoring division, one quotient bit per clock, then RNE rounding.
// Optional macro FPDIV_EARLY_TERM_EN ends the iteration early once the remainder reaches zero.
package specialcases;
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp;

    typedef enum logic [2:0] {
        zero, normalizedNumber, positive_infinity, negative_infinity, nan, overflow, underflow
    } SpecialCases;
endpackage

module fp_divider
    import specialcases::*;
#(
    parameter logic [22:0] NAN_MANTISSA = 23'h400000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  fp           a,
    input  fp           b,
    output logic        out_valid,
    input  logic        out_ready,
    output fp           result,
    output SpecialCases number_form,
    output logic        div_by_zero_flag
);

    typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;
    state_t state, state_nx;

    logic               sign_q;
    logic signed [9:0]  e_base;
    logic [24:0]        r_q, d_q;
    logic [26:0]        q_q;
    logic [4:0]         cnt;

    // operand classification, evaluated on the raw inputs at accept
    logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, s_in;
    logic        sp_hit, sp_dbz;
    fp           sp_res;
    SpecialCases sp_form;

    assign a_zero = (a.exp == 8'h00);
    assign b_zero = (b.exp == 8'h00);
    assign a_inf  = (a.exp == 8'hFF) && (a.mant == '0);
    assign b_inf  = (b.exp == 8'hFF) && (b.mant == '0);
    assign a_nan  = (a.exp == 8'hFF) && (a.mant != '0);
    assign b_nan  = (b.exp == 8'hFF) && (b.mant != '0);
    assign s_in   = a.sign ^ b.sign;

    always_comb begin
        sp_hit  = 1'b1;
        sp_dbz  = 1'b0;
        sp_res  = '0;
        sp_form = zero;
        if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
            sp_res  = {s_in, 8'hFF, NAN_MANTISSA};
            sp_form = nan;
        end else if (a_inf || b_zero) begin
            sp_res  = {s_in, 8'hFF, 23'h0};
            sp_form = s_in ? negative_infinity : positive_infinity;
            sp_dbz  = b_zero;
        end else if (a_zero || b_inf) begin
            sp_res  = {s_in, 31'h0};
            sp_form = zero;
        end else begin
            sp_hit  = 1'b0;
        end
    end

    // one restoring step; r stays below 2*d so the shift never overflows 25 bits
    logic        ge;
    logic [24:0] r_sub, r_nx;
    logic [26:0] q_nx, q_shift;
    logic        early_stop;

    assign ge      = (r_q >= d_q);
    assign r_sub   = ge ? (r_q - d_q) : r_q;
    assign r_nx    = r_sub << 1;
    assign q_nx    = {q_q[25:0], ge};
    assign q_shift = q_nx << (5'd26 - cnt);

`ifdef FPDIV_EARLY_TERM_EN
    assign early_stop = (r_nx == '0);
`else
    assign early_stop = 1'b0;
`endif

    // rounding and exponent assembly from the finished quotient
    logic [22:0]       mant_sel;
    logic [23:0]       mant_inc;
    logic              guard, sticky, adj, rnd_up, carry;
    logic signed [9:0] e_fin;
    fp                 rnd_res;
    SpecialCases       rnd_form;

    always_comb begin
        if (q_q[26]) begin
            mant_sel = q_q[25:3];
            guard    = q_q[2];
            sticky   = (|q_q[1:0]) | (r_q != '0);
            adj      = 1'b0;
        end else begin
            mant_sel = q_q[24:2];
            guard    = q_q[1];
            sticky   = q_q[0] | (r_q != '0);
            adj      = 1'b1;
        end
        rnd_up   = guard && (sticky || mant_sel[0]);
        mant_inc = {1'b0, mant_sel} + {23'h0, rnd_up};
        carry    = mant_inc[23];
        e_fin    = e_base - $signed({9'h0, adj}) + $signed({9'h0, carry});
        if (e_fin >= 10'sd255) begin
            rnd_res  = {sign_q, 8'hFF, 23'h0};
            rnd_form = overflow;
        end else if (e_fin <= 10'sd0) begin
            rnd_res  = {sign_q, 31'h0};
            rnd_form = underflow;
        end else begin
            rnd_res  = {sign_q, e_fin[7:0], mant_inc[22:0]};
            rnd_form = normalizedNumber;
        end
    end

    assign in_ready = (state == IDLE) && rst_n;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = sp_hit ? DONE : DIVIDE;
            DIVIDE:  if (cnt == 5'd26 || early_stop) state_nx = ROUND;
            ROUND:   state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sign_q           <= 1'b0;
            e_base           <= '0;
            r_q              <= '0;
            d_q              <= '0;
            q_q              <= '0;
            cnt              <= '0;
            out_valid        <= 1'b0;
            result           <= '0;
            number_form      <= zero;
            div_by_zero_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sign_q <= s_in;
                    e_base <= $signed({2'b00, a.exp}) - $signed({2'b00, b.exp}) + 10'sd127;
                    r_q    <= {2'b01, a.mant};
                    d_q    <= {2'b01, b.mant};
                    q_q    <= '0;
                    cnt    <= '0;
                    if (sp_hit) begin
                        result           <= sp_res;
                        number_form      <= sp_form;
                        div_by_zero_flag <= sp_dbz;
                        out_valid        <= 1'b1;
                    end
                end
                DIVIDE: begin
                    r_q <= r_nx;
                    q_q <= early_stop ? q_shift : q_nx;
                    cnt <= cnt + 5'd1;
                end
                ROUND: begin
                    result           <= rnd_res;
                    number_form      <= rnd_form;
                    div_by_zero_flag <= 1'b0;
                    out_valid        <= 1'b1;
                end
                DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_divider.sv
// Directed-vector bench for fp_divider: table of operand pairs with hand-computed results,
// plus handshake-hold and mid-divide reset sequences.
module tb_fp_divider;
    import specialcases::*;

`ifdef FPDIV_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, div_by_zero_flag;
    fp           a, b, result;
    SpecialCases number_form;

    int n_tests = 0;
    int n_fail  = 0;

    fp_divider dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .number_form(number_form), .div_by_zero_flag(div_by_zero_flag)
    );

    always #5 clk = ~clk;

    // lat_* = clock edges after the accept edge until out_valid is seen high
    typedef struct {
        logic [31:0] a, b, res;
        SpecialCases form;
        logic        dbz;
        int          lat_fix, lat_et;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic accept(input logic [31:0] av, input logic [31:0] bv);
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        a = av; b = bv; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handoff();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_after_handoff", 32'(out_valid), 32'd0);
        chk("in_ready_after_handoff", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        vecs.push_back('{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, normalizedNumber,  1'b0, 28, 28});
        vecs.push_back('{32'h40C00000, 32'h40400000, 32'h40000000, normalizedNumber,  1'b0, 28, 2});
        vecs.push_back('{32'hC0C00000, 32'h40400000, 32'hC0000000, normalizedNumber,  1'b0, 28, 2});
        vecs.push_back('{32'h40400000, 32'h40000000, 32'h3FC00000, normalizedNumber,  1'b0, 28, 3});
        vecs.push_back('{32'hC0400000, 32'hBF800000, 32'h40400000, normalizedNumber,  1'b0, 28, 3});
        vecs.push_back('{32'h3F800000, 32'h00000000, 32'h7F800000, positive_infinity, 1'b1, 0, 0});
        vecs.push_back('{32'hBF800000, 32'h00000000, 32'hFF800000, negative_infinity, 1'b1, 0, 0});
        vecs.push_back('{32'h3F800000, 32'h00000001, 32'h7F800000, positive_infinity, 1'b1, 0, 0});
        vecs.push_back('{32'h00000000, 32'h00000000, 32'h7FC00000, nan,               1'b0, 0, 0});
        vecs.push_back('{32'h80000000, 32'h00000000, 32'hFFC00000, nan,               1'b0, 0, 0});
        vecs.push_back('{32'h7F800000, 32'h7F800000, 32'h7FC00000, nan,               1'b0, 0, 0});
        vecs.push_back('{32'h7FC00001, 32'h3F800000, 32'h7FC00000, nan,               1'b0, 0, 0});
        vecs.push_back('{32'h7F800000, 32'h40000000, 32'h7F800000, positive_infinity, 1'b0, 0, 0});
        vecs.push_back('{32'hFF800000, 32'h40000000, 32'hFF800000, negative_infinity, 1'b0, 0, 0});
        vecs.push_back('{32'h40000000, 32'h7F800000, 32'h00000000, zero,              1'b0, 0, 0});
        vecs.push_back('{32'h00000001, 32'h3F800000, 32'h00000000, zero,              1'b0, 0, 0});
        vecs.push_back('{32'h7F000000, 32'h3E800000, 32'h7F800000, overflow,          1'b0, 28, 2});
        vecs.push_back('{32'h00800000, 32'h40000000, 32'h00000000, underflow,         1'b0, 28, 2});

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_form", 32'(number_form), 32'(zero));
        chk("rst_dbz", 32'(div_by_zero_flag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        foreach (vecs[i]) begin
            accept(vecs[i].a, vecs[i].b);
            wait_out(lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(ET ? vecs[i].lat_et : vecs[i].lat_fix));
            chk($sformatf("v%0d_result", i), result, vecs[i].res);
            chk($sformatf("v%0d_form", i), 32'(number_form), 32'(vecs[i].form));
            chk($sformatf("v%0d_dbz", i), 32'(div_by_zero_flag), 32'(vecs[i].dbz));
            handoff();
        end

        // consumer stalls: result must hold and no new operand accepted
        accept(32'h3F800000, 32'h40400000);
        wait_out(lat);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_result", result, 32'h3EAAAAAB);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        handoff();

        // reset in the middle of DIVIDE discards the operation
        accept(32'h3F800000, 32'h40400000);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_result", result, 32'h0);
        chk("midrst_form", 32'(number_form), 32'(zero));
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            chk("midrst_no_output", 32'(out_valid), 32'd0);
        end
        accept(32'h3F800000, 32'h40400000);
        wait_out(lat);
        chk("post_rst_latency", 32'(lat), 32'd28);
        chk("post_rst_result", result, 32'h3EAAAAAB);
        chk("post_rst_form", 32'(number_form), 32'(normalizedNumber));
        handoff();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
